// File: rtl/bcd_scan_display_if.sv
// Bus between the units-counter side and the two-digit seven-segment scan display.
// The producer drives en/units_in; the display block drives the segment bus and status.
interface bcd_scan_display_if;
    logic       en;
    logic [3:0] units_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] tens_out;
    logic       overflow;
    logic       invalid;

    modport master (
        output en, units_in,
        input  seg, an, tens_out, overflow, invalid
    );

    modport slave (
        input  en, units_in,
        output seg, an, tens_out, overflow, invalid
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Tens-digit counter driven by units-digit wraps, plus a two-digit time-multiplexed
// seven-segment scanner showing units (an=01) and tens (an=10) on one shared bus.
module bcd_scan_display #(
    parameter int SCAN_DIV = 4,
    parameter int MAX_TENS = 9
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_display_if.slave  disp
);

    localparam int             DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]     TENS_LAST = 4'(MAX_TENS);

    typedef enum logic {DIG0, DIG1} state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [3:0]       units_q, prev_q;
    logic [3:0]       tens_q, tens_d;
    logic             overflow_q, overflow_d;
    logic             invalid_q, invalid_d;
    logic [DIV_W-1:0] div_q, div_d;
    state_e           state_q, state_d;
    logic [1:0]       an_q, an_d;
    logic [6:0]       seg_q;
    logic [3:0]       digit_sel;
    logic             wrap;

    // prev_q >= 9 also catches a counter that briefly emitted 10 before returning to 0
    assign wrap = (units_q == 4'd0) && (prev_q >= 4'd9);

    always_comb begin
        tens_d     = tens_q;
        overflow_d = 1'b0;
        if (wrap && disp.en) begin
            if (tens_q >= TENS_LAST) begin
                tens_d     = 4'd0;
                overflow_d = 1'b1;
            end else begin
                tens_d = tens_q + 4'd1;
            end
        end
    end

    assign invalid_d = (units_q > 4'd9);
    assign div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIG0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (div_q == DIV_LAST) begin
            state_d = (state_q == DIG0) ? DIG1 : DIG0;
        end
    end

    // FSM: outputs, registered below so seg and an always come from the same state
    always_comb begin
        an_d      = 2'b01;
        digit_sel = units_q;
        if (state_q == DIG1) begin
            an_d      = 2'b10;
            digit_sel = tens_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            units_q    <= 4'd0;
            prev_q     <= 4'd0;
            tens_q     <= 4'd0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            an_q       <= 2'b00;
            seg_q      <= 7'h00;
        end else begin
            units_q    <= disp.units_in;
            prev_q     <= units_q;
            tens_q     <= tens_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
            an_q       <= an_d;
            seg_q      <= seg_decode(digit_sel);
        end
    end

    assign disp.seg      = seg_q;
    assign disp.an       = an_q;
    assign disp.tens_out = tens_q;
    assign disp.overflow = overflow_q;
    assign disp.invalid  = invalid_q;

endmodule
